// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life engine.
// Holds the control state encoding and the row/column to bit-index mapping.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Row 0 occupies the lowest COLS bits; columns increase with bit index.
    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/life_next.sv
// Combinational B3/S23 next-generation function for a ROWS x COLS grid.
// Define LIFE_TORUS_EN to wrap rows and columns; otherwise off-grid cells read as dead.
module life_next
    import life_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic [ROWS*COLS-1:0] grid_i,
    output logic [ROWS*COLS-1:0] next_o
);

    function automatic logic [3:0] count_at(input logic [ROWS*COLS-1:0] g,
                                            input int r, input int c);
        logic [3:0] n;
        int rr;
        int cc;
        n = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0)) begin
                    rr = r + dr;
                    cc = c + dc;
`ifdef LIFE_TORUS_EN
                    if (rr < 0) rr = ROWS - 1;
                    else if (rr >= ROWS) rr = 0;
                    if (cc < 0) cc = COLS - 1;
                    else if (cc >= COLS) cc = 0;
                    n = n + {3'b000, g[cell_idx(rr, cc, COLS)]};
`else
                    if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                        n = n + {3'b000, g[cell_idx(rr, cc, COLS)]};
`endif
                end
            end
        end
        return n;
    endfunction

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [3:0] cnt;
            assign cnt = count_at(grid_i, r, c);
            assign next_o[r*COLS+c] = (cnt == 4'd3) || (grid_i[r*COLS+c] && (cnt == 4'd2));
        end
    end

endmodule

// File: rtl/life_grid.sv
// Game-of-Life engine: grid register, IDLE/RUN/HALT control, generation divider,
// saturating generation counter and sticky still/extinct flags. Torus mode via LIFE_TORUS_EN.
module life_grid
    import life_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int PERIOD = 1,
    parameter int GEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 run,
    input  logic                 step,
    output logic [ROWS*COLS-1:0] q,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 extinct,
    output logic                 halted
);

    localparam int N     = ROWS * COLS;
    localparam int DIV_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     grid_q, grid_d, next;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             stable_q, stable_d;
    logic             extinct_q, extinct_d;
    logic             halted_q;
    logic             advance;

    life_next #(.ROWS(ROWS), .COLS(COLS)) u_next (
        .grid_i (grid_q),
        .next_o (next)
    );

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        gen_d     = gen_q;
        div_d     = div_q;
        stable_d  = stable_q;
        extinct_d = extinct_q;
        advance   = 1'b0;

        if (load) begin
            state_d   = IDLE;
            grid_d    = seed;
            gen_d     = '0;
            div_d     = '0;
            stable_d  = 1'b0;
            extinct_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // step has priority; run is re-sampled next cycle.
                    if (step) begin
                        advance = 1'b1;
                    end else if (run) begin
                        state_d = RUN;
                        div_d   = '0;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_d = IDLE;
                        div_d   = '0;
                    end else if (div_q == DIV_LAST) begin
                        advance = 1'b1;
                        div_d   = '0;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: ;
            endcase

            if (advance) begin
                grid_d    = next;
                gen_d     = (gen_q == '1) ? gen_q : gen_q + 1'b1;
                stable_d  = (next == grid_q);
                extinct_d = (next == '0);
                if ((next == grid_q) || (next == '0))
                    state_d = HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grid_q    <= '0;
            gen_q     <= '0;
            div_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            gen_q     <= gen_d;
            div_q     <= div_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
            halted_q  <= (state_d == HALT);
        end
    end

    assign q         = grid_q;
    assign gen_count = gen_q;
    assign stable    = stable_q;
    assign extinct   = extinct_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_life_grid.sv
// Directed bench for life_grid: default, PERIOD=4 and GEN_W=2 instances share one stimulus.
// Expected torus results are selected by LIFE_TORUS_EN.
module tb_life_grid;

    localparam int N = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, load, run, step;
    logic [N-1:0] seed;

    logic [N-1:0] q, qDiv, qSat;
    logic [15:0]  gen, genDiv;
    logic [1:0]   genSat;
    logic         stable, extinct, halted;
    logic         stableDiv, extinctDiv, haltedDiv;
    logic         stableSat, extinctSat, haltedSat;

    int checks   = 0;
    int failures = 0;

    life_grid dut (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .q(q), .gen_count(gen), .stable(stable), .extinct(extinct), .halted(halted)
    );

    life_grid #(.PERIOD(4)) dutDiv (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .q(qDiv), .gen_count(genDiv), .stable(stableDiv), .extinct(extinctDiv), .halted(haltedDiv)
    );

    life_grid #(.GEN_W(2)) dutSat (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .q(qSat), .gen_count(genSat), .stable(stableSat), .extinct(extinctSat), .halted(haltedSat)
    );

    // Builds a grid mask from up to four bit positions; negative entries are unused.
    function automatic logic [N-1:0] mk(input int a, input int b, input int c, input int d);
        logic [N-1:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        if (d >= 0) m[d] = 1'b1;
        return m;
    endfunction

    logic [N-1:0] horiz, vert, block;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doLoad(input logic [N-1:0] pattern);
        seed = pattern;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; run = 1'b0; step = 1'b0; seed = '0;
        tick();
        tick();
        checks++;
        if ({q, gen, stable, extinct, halted} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_main got q=%h gen=%0d s=%b e=%b h=%b want all zero",
                     q, gen, stable, extinct, halted);
        end
        checks++;
        if ({qDiv, genDiv, haltedDiv, qSat, genSat, haltedSat} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_aux got qDiv=%h genDiv=%0d qSat=%h genSat=%0d want zero",
                     qDiv, genDiv, qSat, genSat);
        end
        reset = 1'b0;
    endtask

    task automatic test_blinker();
        doLoad(horiz);
        checks++;
        if ({q, gen} !== {horiz, 16'd0}) begin
            failures++;
            $display("[TB] FAIL blink_load got q=%h gen=%0d want q=%h gen=0", q, gen, horiz);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if ({q, gen, stable, halted} !== {vert, 16'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL blink_step1 got q=%h gen=%0d s=%b h=%b want q=%h gen=1 s=0 h=0",
                     q, gen, stable, halted, vert);
        end
        tick();
        checks++;
        if ({q, gen} !== {vert, 16'd1}) begin
            failures++;
            $display("[TB] FAIL blink_idle got q=%h gen=%0d want q=%h gen=1", q, gen, vert);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if ({q, gen, stable, extinct, halted} !== {horiz, 16'd2, 3'b000}) begin
            failures++;
            $display("[TB] FAIL blink_step2 got q=%h gen=%0d s=%b e=%b h=%b want q=%h gen=2 flags=0",
                     q, gen, stable, extinct, halted, horiz);
        end
    endtask

    task automatic test_still_life();
        doLoad(block);
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if ({q, gen, stable, extinct, halted} !== {block, 16'd1, 3'b101}) begin
            failures++;
            $display("[TB] FAIL still_step got q=%h gen=%0d s=%b e=%b h=%b want q=%h gen=1 s=1 e=0 h=1",
                     q, gen, stable, extinct, halted, block);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        run = 1'b1;
        tick();
        tick();
        tick();
        run = 1'b0;
        checks++;
        if ({q, gen, stable, halted} !== {block, 16'd1, 2'b11}) begin
            failures++;
            $display("[TB] FAIL still_frozen got q=%h gen=%0d s=%b h=%b want q=%h gen=1 s=1 h=1",
                     q, gen, stable, halted, block);
        end
        doLoad(block);
        checks++;
        if ({q, gen, stable, extinct, halted} !== {block, 16'd0, 3'b000}) begin
            failures++;
            $display("[TB] FAIL still_reload got gen=%0d s=%b e=%b h=%b want gen=0 flags=0",
                     gen, stable, extinct, halted);
        end
    endtask

    task automatic test_extinction();
        doLoad(mk(27, -1, -1, -1));
        run = 1'b1;
        tick();
        checks++;
        if ({q, gen} !== {mk(27, -1, -1, -1), 16'd0}) begin
            failures++;
            $display("[TB] FAIL ext_entry got q=%h gen=%0d want single cell gen=0", q, gen);
        end
        tick();
        checks++;
        if ({q, gen, stable, extinct, halted} !== {64'd0, 16'd1, 3'b011}) begin
            failures++;
            $display("[TB] FAIL ext_halt got q=%h gen=%0d s=%b e=%b h=%b want q=0 gen=1 s=0 e=1 h=1",
                     q, gen, stable, extinct, halted);
        end
        run = 1'b0;
    endtask

    task automatic test_boundary();
        logic [N-1:0] want;
`ifdef LIFE_TORUS_EN
        want = mk(1, 9, 57, -1);
`else
        want = mk(1, 9, -1, -1);
`endif
        doLoad(mk(0, 1, 2, -1));
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if ({q, gen, halted} !== {want, 16'd1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL boundary got q=%h gen=%0d h=%b want q=%h gen=1 h=0", q, gen, halted, want);
        end
    endtask

    task automatic test_divider();
        int expDiv;
        doLoad(horiz);
        run = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            expDiv = (k - 1) / 4;
            checks++;
            if ({genDiv, qDiv} !== {16'(expDiv), (expDiv % 2 == 1) ? vert : horiz}) begin
                failures++;
                $display("[TB] FAIL div_edge%0d got gen=%0d q=%h want gen=%0d", k, genDiv, qDiv, expDiv);
            end
            checks++;
            if (gen !== 16'(k - 1)) begin
                failures++;
                $display("[TB] FAIL run_edge%0d got gen=%0d want %0d", k, gen, k - 1);
            end
            checks++;
            if (genSat !== ((k - 1 > 3) ? 2'd3 : 2'(k - 1))) begin
                failures++;
                $display("[TB] FAIL sat_edge%0d got gen=%0d want %0d", k, genSat, (k - 1 > 3) ? 3 : k - 1);
            end
        end
        tick();
        tick();
        run = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if ({genDiv, qDiv, haltedDiv} !== {16'd4, horiz, 1'b0}) begin
            failures++;
            $display("[TB] FAIL div_drop got gen=%0d q=%h h=%b want gen=4 q=%h h=0",
                     genDiv, qDiv, haltedDiv, horiz);
        end
        checks++;
        if ({qSat, genSat, haltedSat} !== {horiz, 2'd3, 1'b0}) begin
            failures++;
            $display("[TB] FAIL sat_hold got q=%h gen=%0d h=%b want q=%h gen=3 h=0",
                     qSat, genSat, haltedSat, horiz);
        end
    endtask

    task automatic test_reset_in_run();
        run = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({q, gen, stable, extinct, halted, qDiv, genDiv} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_run got q=%h gen=%0d s=%b e=%b h=%b genDiv=%0d want all zero",
                     q, gen, stable, extinct, halted, genDiv);
        end
        run = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        seed = horiz;
        load = 1'b1;
        step = 1'b1;
        tick();
        load = 1'b0;
        step = 1'b0;
        checks++;
        if ({q, gen, stable, halted} !== {horiz, 16'd0, 2'b00}) begin
            failures++;
            $display("[TB] FAIL load_step got q=%h gen=%0d want q=%h gen=0", q, gen, horiz);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if ({q, gen} !== {vert, 16'd1}) begin
            failures++;
            $display("[TB] FAIL load_then_step got q=%h gen=%0d want q=%h gen=1", q, gen, vert);
        end
    endtask

    initial begin
        horiz = mk(26, 27, 28, -1);
        vert  = mk(19, 27, 35, -1);
        block = mk(0, 1, 8, 9);
        test_reset();
        test_blinker();
        test_still_life();
        test_extinction();
        test_boundary();
        test_divider();
        test_reset_in_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
